// File: rtl/input_pre_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_pre_reader_if : SRAM read port + output byte stream of the pre-reader
// Revision: 1.0
// ---------------------------------------------------------------------------
interface input_pre_reader_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic          sram_cs;
  logic          sram_we;
  logic          sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output sram_cs, sram_we, sram_wem, sram_addr,
    input  sram_dout,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  sram_cs, sram_we, sram_wem, sram_addr,
    output sram_dout,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/input_pre_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_pre_reader : streams LEN entries from the pre-buffer SRAM (wrapping)
// Revision: 1.0
// ---------------------------------------------------------------------------
module input_pre_reader #(
  parameter int DP = 768,
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int LW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [AW-1:0]       base_addr_i,
  input  logic [LW-1:0]       len_i,
  output logic                busy_o,
  output logic                done_o,
  input_pre_reader_if.master  bus_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued_q;
  logic [LW-1:0] head_idx_q;
  logic [AW-1:0] ptr_q;
  logic          inflight_q;

  logic [DW-1:0] fifo_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_last;
  logic          w_issue;
  logic [2:0]    w_occ;
  logic [AW-1:0] w_ptr_d;

  assign w_valid = (count_q != 2'd0);
  assign w_pop   = w_valid & bus_if.out_ready;
  assign w_push  = inflight_q;
  assign w_last  = w_valid & (head_idx_q == len_q - LW'(1));

  // Occupancy after this cycle's pop, counting the read still in the SRAM pipe.
  assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue = (state_q == S_RUN) && (issued_q < len_q) && (w_occ < 3'd2);
  assign w_ptr_d = (ptr_q == AW'(DP - 1)) ? '0 : ptr_q + AW'(1);

  assign bus_if.sram_cs   = w_issue;
  assign bus_if.sram_we   = 1'b0;
  assign bus_if.sram_wem  = 1'b0;
  assign bus_if.sram_addr = w_issue ? ptr_q : '0;

  assign bus_if.out_valid = w_valid;
  assign bus_if.out_data  = fifo_q[rd_ptr_q];
  assign bus_if.out_last  = w_last;

  assign busy_o = busy_q;
  assign done_o = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      head_idx_q <= '0;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= w_issue;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q      <= len_i;
            ptr_q      <= base_addr_i;
            issued_q   <= '0;
            head_idx_q <= '0;
            busy_q     <= 1'b1;
            if (len_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            ptr_q    <= w_ptr_d;
            issued_q <= issued_q + LW'(1);
          end
          if (w_pop) begin
            head_idx_q <= head_idx_q + LW'(1);
            if (w_last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry skid FIFO; data arrives one cycle after its read was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (w_push) begin
        fifo_q[wr_ptr_q] <= bus_if.sram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (count_q == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_pre_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_input_pre_reader : scoreboard bench for the input pre-buffer read sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_input_pre_reader;
  localparam int DP = 768;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;

  input_pre_reader_if #(.DW(DW), .AW(AW)) bus_if ();

  input_pre_reader #(.DP(DP), .DW(DW), .AW(AW), .LW(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .bus_if      (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DP];
  always @(posedge clk) if (bus_if.sram_cs) bus_if.sram_dout <= mem[bus_if.sram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]    exp_q  [$];
  logic [AW-1:0] addr_q [$];
  int            hs_cnt = 0;
  int            first_valid_cyc = -1;
  int            last_hs_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  logic       bp_en = 1'b0;
  logic [5:0] pat = 6'b101001;
  int         bp_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or a read.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus_if.sram_cs) begin
        if (addr_q.size() == 0) chk("unexpected_cs", 1, 0);
        else chk("sram_addr", int'(bus_if.sram_addr), int'(addr_q.pop_front()));
        chk("sram_we_wem", int'({bus_if.sram_we, bus_if.sram_wem}), 0);
      end
      if (prev_stall) begin
        chk("stall_valid", int'(bus_if.out_valid), 1);
        chk("stall_data", int'(bus_if.out_data), int'(prev_data));
      end
      if (bus_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(bus_if.out_data), int'(e[7:0]));
          chk("out_last", int'(bus_if.out_last), int'(e[8]));
        end
        hs_cnt++;
        if (bus_if.out_last) last_hs_cyc = cyc;
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
    end
  end

  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus_if.out_ready = pat[bp_idx];
        bp_idx = (bp_idx + 1) % 6;
      end else begin
        bus_if.out_ready = 1'b1;
      end
    end
  end

  task automatic push_job(input int b, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (b + i) % DP;
      addr_q.push_back(AW'(a));
      exp_q.push_back({(i == n - 1), mem[a]});
    end
  endtask

  task automatic run_job(input int b, input int n, input int poke, input bit exp_thru);
    int t0;
    bit seen;
    assert (n <= DP);
    push_job(b, n);
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base = AW'(b); len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_after_start", int'(busy), 1);
      if (poke != 0 && k == poke) begin
        start = 1'b1; base = AW'(100); len = LW'(3);
      end
      if (poke != 0 && k == poke + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      if (n == 0) chk("done_cycle_len0", cyc, t0);
      else chk("done_cycle", cyc, last_hs_cyc + 1);
      chk("busy_with_done", int'(busy), 1);
      @(negedge clk);
      chk("done_width", int'(done), 0);
      chk("busy_fall", int'(busy), 0);
    end
    if (n > 0) chk("first_valid_latency", first_valid_cyc - t0, 2);
    else chk("len0_no_valid", first_valid_cyc, -1);
    if (exp_thru) chk("throughput", last_hs_cyc - t0, n + 1);
    chk("leftover_out", exp_q.size(), 0);
    chk("leftover_addr", addr_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus_if.out_valid), 0);
    chk({tag, "_data"}, int'(bus_if.out_data), 0);
    chk({tag, "_last"}, int'(bus_if.out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cs"}, int'(bus_if.sram_cs), 0);
    chk({tag, "_addr"}, int'(bus_if.sram_addr), 0);
  endtask

  initial begin
    int h0;
    bit hit;
    bus_if.sram_dout = '0;
    for (int i = 0; i < DP; i++) mem[i] = DW'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(0, 4, 0, 1'b1);
    run_job(766, 4, 0, 1'b1);

    bp_en = 1'b1;
    run_job(0, 8, 0, 1'b0);
    bp_en = 1'b0;

    run_job(0, 0, 0, 1'b0);
    run_job(10, 6, 2, 1'b1);

    // Reset after three of ten elements have been consumed.
    push_job(0, 10);
    h0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1; base = '0; len = LW'(10);
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk); #1;
      if (hs_cnt == h0 + 3) hit = 1'b1;
    end
    chk("reach_3_handshakes", int'(hit), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_idle_outputs("midjob_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", int'(bus_if.out_valid), 0);
    chk("post_rst_done", int'(done), 0);

    run_job(5, 2, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/input_pre_reader.md
Name: input_pre_reader

Overview:
- Read-side sequencer for the input pre-buffer SRAM (DP x DW, single port, one-cycle registered-address read latency).
- On a start pulse, reads LEN consecutive entries from BASE, wrapping modulo DP, and emits them on a valid/ready byte stream toward the PE array.
- Hides SRAM read latency with a 2-entry buffer.
- Sustains 1 element/cycle while the consumer holds out_ready high.

Parameters:
- DP, 768: SRAM depth (entries).
- DW, 8: data width.
- AW, 10: SRAM address width; 2^AW >= DP.
- LW, 10: length field width; the largest legal length is DP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request pulse; sampled only in IDLE.
- base_addr  in  AW  first entry to read; must be < DP.
- len  in  LW  number of entries to read, 0..DP.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable; tied 0.
- sram_wem  out  1  SRAM write mask; tied 0.
- sram_addr  out  AW  SRAM address.
- sram_dout  in  DW  SRAM read data; valid the cycle after the cs edge.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DW  stream data.
- out_last  out  1  high with the final element of the job.

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, sram_cs, out_valid, out_last = 0; sram_addr, out_data = 0; all counters 0; buffer empty.
- States:
  - IDLE: on start=1, latch base_addr and len. If len=0, go to DONE; otherwise go to RUN.
  - RUN: issue reads and drain the buffer. After the handshake of the last element, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE).
- start is ignored outside IDLE.
- Read issue, combinational per cycle in RUN:
  - pop = out_valid & out_ready.
  - Issue when issued_cnt < len_r and (occupancy + inflight - pop) < 2.
  - On issue: sram_cs=1, sram_we=0, sram_addr = current pointer.
  - sram_cs=0 in every other cycle.
- Address pointer:
  - Starts at base_addr and increments by 1 per issue.
  - Wraps to 0 after DP-1; DP-1 is followed by 0, never DP.
- inflight: set on an issue cycle, cleared on the next cycle. On the edge after an issue, sram_dout is pushed into the buffer.
- Buffer: 2-entry FIFO. The head drives out_data and out_valid = !empty. Push and pop in the same cycle are permitted.
- Buffer data must never be lost or duplicated under any out_ready pattern. The issue rule guarantees no overflow; overflow is an assertion failure.
- out_valid/out_data must hold stable while out_valid=1 and out_ready=0.
- out_last = out_valid & (head element index == len_r-1).
- Latency: the first read issues in the cycle after the start edge. out_valid first rises 2 edges after the start edge.
- Throughput: with out_ready held high, one element per cycle after the first.
- Job length: the job ends on the handshake with out_last=1. done pulses in the following cycle and busy falls with done.
- len=0: no SRAM access, no out_valid. done pulses in the cycle after start; busy is high for that one cycle.
- len > DP is illegal; behaviour is unspecified, and the bench asserts it never occurs.
- Reset mid-job: all state clears immediately; no done pulse; no partial data on out_* after reset deasserts.

Test Plan:
- Preload mem[i]=i[7:0]; start base=0, len=4, out_ready=1 -> cs high 4 consecutive cycles, addr 0..3; out_data 00,01,02,03 on consecutive cycles, first 2 edges after start; out_last on 03; done 1 cycle later.
- Wrap: base=766, len=4 -> sram_addr 766,767,0,1; out_data FE,FF,00,01.
- Backpressure: len=8, out_ready toggled 1,0,0,1,0,1,... -> all 8 values in order, none dropped or duplicated; stable data while stalled; never >2 buffered.
- len=0 -> no sram_cs; no out_valid; busy 1 cycle; done pulse 1 cycle after start.
- start re-asserted during RUN (base=100) -> ignored; original sequence completes unchanged.
- rst asserted after 3 of 10 elements -> outputs go to reset values that cycle; a new job with base=5, len=2 afterwards emits 05,06 only.
